// File: rtl/game_board_if.sv
// Move-write bus between the game controller and the board: one cell write
// per move in, board state and game status out.
interface game_board_if;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic [17:0] gBoard;
  logic        gameIsDone;
  logic [1:0]  winner;
  logic        busy;
  logic        writeRejected;

  modport master (
    output addr, cellState,
    input  gBoard, gameIsDone, winner, busy, writeRejected
  );

  modport slave (
    input  addr, cellState,
    output gBoard, gameIsDone, winner, busy, writeRejected
  );
endinterface

// File: rtl/game_board.sv
// Tic-tac-toe board: accepts one cell write per move, then scans the eight
// winning lines one per cycle and publishes winner / game-over.
module game_board (
  input  logic         ph1,
  input  logic         ph2,
  input  logic         reset,
  game_board_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      r_state;
  logic [17:0] r_board;
  logic [3:0]  r_moves;
  logic [2:0]  r_idx;
  logic        r_done;
  logic [1:0]  r_winner;
  logic        r_busy;
  logic        r_rej;

  logic [1:0]  w_cells [9];
  logic [17:0] w_board_wr;
  logic [3:0]  w_a, w_b, w_c;
  logic [1:0]  w_va, w_vb, w_vc;
  logic        w_attempt, w_legal, w_win;
  logic        w_unused;

  // State advances on ph1 rising; ph2 only completes the two-phase pair.
  assign w_unused = ph2;

  for (genvar g = 0; g < 9; g++) begin : g_cell
    assign w_cells[g] = r_board[2*g+1:2*g];
    assign w_board_wr[2*g+1:2*g] = (bus.addr == 4'(g)) ? bus.cellState : w_cells[g];
  end

  always_comb begin
    w_a = 4'd0; w_b = 4'd1; w_c = 4'd2;
    case (r_idx)
      3'd0: begin w_a = 4'd0; w_b = 4'd1; w_c = 4'd2; end
      3'd1: begin w_a = 4'd3; w_b = 4'd4; w_c = 4'd5; end
      3'd2: begin w_a = 4'd6; w_b = 4'd7; w_c = 4'd8; end
      3'd3: begin w_a = 4'd0; w_b = 4'd3; w_c = 4'd6; end
      3'd4: begin w_a = 4'd1; w_b = 4'd4; w_c = 4'd7; end
      3'd5: begin w_a = 4'd2; w_b = 4'd5; w_c = 4'd8; end
      3'd6: begin w_a = 4'd0; w_b = 4'd4; w_c = 4'd8; end
      default: begin w_a = 4'd2; w_b = 4'd4; w_c = 4'd6; end
    endcase
  end

  assign w_va = w_cells[w_a];
  assign w_vb = w_cells[w_b];
  assign w_vc = w_cells[w_c];
  assign w_win = (w_va != 2'b00) && (w_va == w_vb) && (w_vb == w_vc);

  // cellState[1] set means O (11) or X (10); EMPTY and 01 are not playable.
  assign w_attempt = (bus.addr != 4'hF);
  assign w_legal   = (bus.addr <= 4'd8) && bus.cellState[1] &&
                     (bus.addr <= 4'd8 ? (w_cells[bus.addr] == 2'b00) : 1'b0);

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state  <= IDLE;
      r_board  <= '0;
      r_moves  <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_winner <= 2'b00;
      r_busy   <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      r_rej <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_attempt) begin
            if (w_legal) begin
              r_board <= w_board_wr;
              r_moves <= (r_moves == 4'd9) ? 4'd9 : r_moves + 4'd1;
              r_idx   <= '0;
              r_state <= SCAN;
              r_busy  <= 1'b1;
            end else begin
              r_rej <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (w_attempt) r_rej <= 1'b1;
          if (w_win) begin
            r_winner <= w_va;
            r_done   <= 1'b1;
            r_state  <= DONE;
            r_busy   <= 1'b0;
          end else if (r_idx == 3'd7) begin
            r_busy <= 1'b0;
            if (r_moves == 4'd9) begin
              r_winner <= 2'b01;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        DONE: begin
          if (w_attempt) r_rej <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gBoard        = r_board;
  assign bus.gameIsDone    = r_done;
  assign bus.winner        = r_winner;
  assign bus.busy          = r_busy;
  assign bus.writeRejected = r_rej;
endmodule

// File: tb/tb_game_board.sv
// Scoreboard bench for game_board: stimulus queues expected rejection pulses
// and scan completions; a monitor pops and compares as the DUT presents them.
module tb_game_board;
  logic ph1, ph2, reset;
  game_board_if bus ();

  game_board dut (.ph1(ph1), .ph2(ph2), .reset(reset), .bus(bus));

  typedef struct {
    int          cyc;
    logic [17:0] brd;
    logic        done;
    logic [1:0]  win;
  } exp_t;

  exp_t rq[$];
  exp_t sq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  logic [1:0] m_cell [9];
  logic       m_done;
  logic [1:0] m_win;

  localparam logic [1:0] O = 2'b11, X = 2'b10;

  initial begin
    ph1 = 0; ph2 = 0;
    forever begin
      ph1 = 1; #4; ph1 = 0; #1;
      ph2 = 1; #4; ph2 = 0; #1;
    end
  end

  always @(posedge ph1) cyc <= cyc + 1;

  function automatic logic [17:0] pack();
    return {m_cell[8], m_cell[7], m_cell[6], m_cell[5], m_cell[4],
            m_cell[3], m_cell[2], m_cell[1], m_cell[0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_cell[i] = 2'b00;
    m_done = 0;
    m_win  = 2'b00;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e);
    checks++;
    if (e.cyc != cyc || e.brd !== bus.gBoard || e.done !== bus.gameIsDone || e.win !== bus.winner) begin
      errors++;
      $display("FAIL %s got cyc=%0d brd=%h done=%0b win=%b want cyc=%0d brd=%h done=%0b win=%b",
               nm, cyc, bus.gBoard, bus.gameIsDone, bus.winner, e.cyc, e.brd, e.done, e.win);
    end
  endtask

  // Monitor samples mid-cycle on ph2, well away from the ph1 update edge.
  initial begin
    logic prev_busy;
    prev_busy = 0;
    forever begin
      @(posedge ph2);
      if (mon_en) begin
        if (bus.writeRejected) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_reject cyc=%0d got=1 want=0", cyc);
          end else cmp("reject", rq.pop_front());
        end
        if (prev_busy && !bus.busy) begin
          if (sq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_scan_end cyc=%0d got=busy_fall want=none", cyc);
          end else cmp("scan_end", sq.pop_front());
        end
      end
      prev_busy = bus.busy;
    end
  end

  // res: -2 rejected, -1 accepted no win, 0..7 win on that line, 8 tie.
  task automatic mv(input logic [3:0] a, input logic [1:0] s, input int res, input logic [1:0] w);
    int n;
    n = cyc;
    bus.addr = a;
    bus.cellState = s;
    if (res == -2) rq.push_back('{n + 1, pack(), m_done, m_win});
    else begin
      m_cell[a] = s;
      if (res == -1) sq.push_back('{n + 9, pack(), 1'b0, 2'b00});
      else if (res == 8) begin
        m_done = 1; m_win = 2'b01;
        sq.push_back('{n + 9, pack(), 1'b1, 2'b01});
      end else begin
        m_done = 1; m_win = w;
        sq.push_back('{n + 2 + res, pack(), 1'b1, w});
      end
    end
    @(posedge ph1); #1;
    bus.addr = 4'hF;
    bus.cellState = 2'b00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy; i++) begin
      @(posedge ph1); #1;
    end
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL wait_idle cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge ph1); #1;
    reset = 0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    bus.addr = 4'hF;
    bus.cellState = 2'b00;
    model_clear();
    repeat (3) @(posedge ph1);
    #1;
    reset = 0;
    mon_en = 1;
    chk("rst_board", 32'(bus.gBoard), 32'h0);
    chk("rst_done", 32'(bus.gameIsDone), 32'h0);
    chk("rst_winner", 32'(bus.winner), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_rej", 32'(bus.writeRejected), 32'h0);
    repeat (5) @(posedge ph1);
    #1;
    chk("idle_board", 32'(bus.gBoard), 32'h0);

    // O at cell 4: board visible and busy at n+1, busy high through n+8
    mv(4'd4, O, -1, 2'b00);
    chk("o4_cell", 32'(bus.gBoard[9:8]), 32'h3);
    chk("o4_busy_n1", 32'(bus.busy), 32'h1);
    for (int i = 2; i <= 8; i++) begin
      @(posedge ph1); #1;
      chk("o4_busy_mid", 32'(bus.busy), 32'h1);
    end
    wait_idle();
    chk("o4_winner", 32'(bus.winner), 32'h0);
    do_reset();

    // Row 0 win for O, then a write in DONE is rejected
    mv(4'd0, O, -1, 2'b00); wait_idle();
    mv(4'd3, X, -1, 2'b00); wait_idle();
    mv(4'd1, O, -1, 2'b00); wait_idle();
    mv(4'd4, X, -1, 2'b00); wait_idle();
    mv(4'd2, O, 0, O);      wait_idle();
    mv(4'd8, X, -2, 2'b00);
    repeat (2) @(posedge ph1);
    #1;
    chk("win_board_hold", 32'(bus.gBoard), 32'(pack()));
    do_reset();

    // Nine-move draw
    mv(4'd0, O, -1, 2'b00); wait_idle();
    mv(4'd1, X, -1, 2'b00); wait_idle();
    mv(4'd2, O, -1, 2'b00); wait_idle();
    mv(4'd4, X, -1, 2'b00); wait_idle();
    mv(4'd3, O, -1, 2'b00); wait_idle();
    mv(4'd5, X, -1, 2'b00); wait_idle();
    mv(4'd7, O, -1, 2'b00); wait_idle();
    mv(4'd6, X, -1, 2'b00); wait_idle();
    mv(4'd8, O, 8, 2'b00);  wait_idle();
    do_reset();

    // Rejections: back-to-back during scan, then illegal writes while idle
    mv(4'd4, O, -1, 2'b00);
    mv(4'd0, X, -2, 2'b00);
    mv(4'd1, X, -2, 2'b00);
    wait_idle();
    mv(4'd4, X, -2, 2'b00);
    mv(4'd9, O, -2, 2'b00);
    mv(4'd14, X, -2, 2'b00);
    mv(4'd0, 2'b00, -2, 2'b00);
    mv(4'd0, 2'b01, -2, 2'b00);
    repeat (2) @(posedge ph1);
    #1;
    chk("rej_board_hold", 32'(bus.gBoard), 32'(pack()));
    do_reset();

    // Reset asserted in cycle n+3 of a scan aborts it
    mv(4'd4, O, -1, 2'b00);
    sq.delete(sq.size() - 1);
    @(posedge ph1); #1;
    @(posedge ph1); #1;
    reset = 1;
    sq.push_back('{cyc + 1, 18'h0, 1'b0, 2'b00});
    @(posedge ph1); #1;
    reset = 0;
    model_clear();
    chk("mid_rst_board", 32'(bus.gBoard), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_done", 32'(bus.gameIsDone), 32'h0);
    mv(4'd4, X, -1, 2'b00);
    chk("post_rst_accept", 32'(bus.busy), 32'h1);
    wait_idle();

    repeat (4) @(posedge ph1);
    #1;
    chk("rq_empty", 32'(rq.size()), 32'h0);
    chk("sq_empty", 32'(sq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
